// File: rtl/hex_scroll_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_scroll_pkg
//  Purpose  : Shared constants, state encoding and ring-index helper for the
//             seven-segment scrolling display blocks.
//  Contents : SEG_BLANK, RING_LEN, NUM_HEX, NUM_SYM, state_e, ring_idx()
//  Revision : 1.0 - initial release
// ============================================================================
package hex_scroll_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;  // all segments off (active-low)
  localparam int         RING_LEN  = 14;     // 8 symbols + 6 trailing blanks
  localparam int         NUM_HEX   = 6;
  localparam int         NUM_SYM   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // (pos + off) mod RING_LEN; pos is always < RING_LEN and off < NUM_HEX,
  // so a single conditional subtract is enough.
  function automatic logic [3:0] ring_idx(input logic [3:0] pos, input int off);
    int s;
    s = int'(pos) + off;
    if (s >= RING_LEN) s = s - RING_LEN;
    return 4'(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scroll_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : scroll_tick_gen
//  Purpose  : Prescaler producing a one-cycle tick every TICK_DIV enabled
//             clock cycles. Holds its count while en=0; clr forces zero and
//             wins over a same-cycle count.
//  Ports    : CLK  - clock
//             R    - synchronous reset, active-low
//             clr  - synchronous clear of the count
//             en   - count enable
//             tick - high in the enabled cycle where the count is TICK_DIV-1
//  Revision : 1.0 - initial release
// ============================================================================
module scroll_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic CLK,
  input  logic R,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!R) cnt_q <= '0;
    else    cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/hex_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : hex_scroller
//  Purpose  : Scrolls 8 seven-segment symbols right-to-left across HEX5..HEX0
//             through a 14-entry ring (8 symbols + 6 blanks).
//  Ports    : CLK        - clock
//             R          - synchronous reset, active-low
//             E          - 1 = run, 0 = freeze display and prescaler
//             LD         - load strobe, captures data
//             data[63:0] - byte k = symbol k, bits [6:0] active-low segments
//             HEX5..HEX0 - registered segment outputs, active-low
//             pos[3:0]   - current scroll position 0..13
//             WRAP       - one-cycle pulse when pos wraps 13 -> 0
//             busy       - high in the RUN state
//  Options  : HEX_SCROLL_PAUSE_EN - dwell PAUSE_TICKS extra ticks at pos 0
//             after every wrap
//  Revision : 1.0 - initial release
// ============================================================================
module hex_scroller
  import hex_scroll_pkg::*;
#(
  parameter int TICK_DIV    = 25000000,
  parameter int PAUSE_TICKS = 4
) (
  input  logic        CLK,
  input  logic        R,
  input  logic        E,
  input  logic        LD,
  input  logic [63:0] data,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0,
  output logic [3:0]  pos,
  output logic        WRAP,
  output logic        busy
);

  if (TICK_DIV < 2 || PAUSE_TICKS < 0) begin : g_bad_params
    $error("hex_scroller: TICK_DIV must be >= 2 and PAUSE_TICKS >= 0");
  end

  localparam logic [3:0] POS_LAST = 4'(RING_LEN - 1);

  state_e                        state_q, state_d;
  logic [RING_LEN-1:0][6:0]      ring_q, ring_d;
  logic [3:0]                    pos_q, pos_d;
  logic                          wrap_q, wrap_d;
  logic [NUM_HEX-1:0][6:0]       hex_q, hex_d;
  logic                          tick;

`ifdef HEX_SCROLL_PAUSE_EN
  localparam int PW = (PAUSE_TICKS < 1) ? 1 : $clog2(PAUSE_TICKS + 1);
  logic [PW-1:0] pause_q, pause_d;
`endif

  // Bit 7 of every byte carries no segment.
  logic sym_msb_unused;
  assign sym_msb_unused = ^{data[63], data[55], data[47], data[39],
                            data[31], data[23], data[15], data[7]};

  // Prescaler runs whenever something is loaded and E is high, so a resume
  // from HOLD counts in the same cycle E rises.
  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .R    (R),
    .clr  (LD),
    .en   (E && (state_q != IDLE)),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    if (LD) begin
      state_d = E ? RUN : HOLD;
    end else begin
      case (state_q)
        RUN:     if (!E) state_d = HOLD;
        HOLD:    if (E)  state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ring_d = ring_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
`ifdef HEX_SCROLL_PAUSE_EN
    pause_d = pause_q;
`endif
    if (LD) begin
      // Load wins over a same-cycle tick: position restarts at 0, no WRAP.
      for (int k = 0; k < NUM_SYM; k++) begin
        ring_d[k] = data[8*(NUM_SYM-1-k) +: 7];
      end
      for (int k = NUM_SYM; k < RING_LEN; k++) begin
        ring_d[k] = SEG_BLANK;
      end
      pos_d = '0;
`ifdef HEX_SCROLL_PAUSE_EN
      pause_d = '0;
`endif
    end else if (tick) begin
`ifdef HEX_SCROLL_PAUSE_EN
      if (pause_q != '0) begin
        pause_d = pause_q - PW'(1);
      end else if (pos_q == POS_LAST) begin
        pos_d   = '0;
        wrap_d  = 1'b1;
        pause_d = PW'(PAUSE_TICKS);
      end else begin
        pos_d = pos_q + 4'd1;
      end
`else
      if (pos_q == POS_LAST) begin
        pos_d  = '0;
        wrap_d = 1'b1;
      end else begin
        pos_d = pos_q + 4'd1;
      end
`endif
    end
  end

  // Outputs trail ring/pos by one cycle.
  always_comb begin
    hex_d = hex_q;
    for (int i = 0; i < NUM_HEX; i++) begin
      hex_d[NUM_HEX-1-i] = ring_q[ring_idx(pos_q, i)];
    end
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      state_q <= IDLE;
      ring_q  <= {RING_LEN{SEG_BLANK}};
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      hex_q   <= {NUM_HEX{SEG_BLANK}};
`ifdef HEX_SCROLL_PAUSE_EN
      pause_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
`ifdef HEX_SCROLL_PAUSE_EN
      pause_q <= pause_d;
`endif
    end
  end

  assign HEX5 = hex_q[5];
  assign HEX4 = hex_q[4];
  assign HEX3 = hex_q[3];
  assign HEX2 = hex_q[2];
  assign HEX1 = hex_q[1];
  assign HEX0 = hex_q[0];
  assign pos  = pos_q;
  assign WRAP = wrap_q;
  assign busy = (state_q == RUN);

endmodule
`default_nettype wire
